// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with a per-register busy scoreboard.
// Combinational reads (optionally forwarding same-cycle write data), writes and
// scoreboard updates on the rising clock edge, synchronous active-high reset.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   ra / rd / rbusy     NREAD read ports (flat: port i at [i*AW +: AW] etc.)
//   we / wa / wd        writeback port; also clears the busy bit of wa
//   iss_en / iss_a      issue of an instruction that will write iss_a (sets busy)
//   iss_conflict        issue targets a register still busy (WAW)
//   busy_cnt            number of registers currently marked busy

// One read port: address decode, zero register, bypass and busy lookup.
module regfile_sb_rport #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic [AW-1:0]                 ra,
    input  logic [DEPTH-1:0][WIDTH-1:0]   mem,
    input  logic [DEPTH-1:0]              busy,
    input  logic                          we,
    input  logic [AW-1:0]                 wa,
    input  logic [WIDTH-1:0]              wd,
    output logic [WIDTH-1:0]              rd,
    output logic                          rbusy
);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    // Extra top bit keeps the range check meaningful for power-of-2 depths.
    logic ra_ok;
    assign ra_ok = {1'b0, ra} < DEPTH_W;

    always_comb begin
        rd    = '0;
        rbusy = 1'b0;
        if (!ra_ok || (ZERO_REG != 0 && ra == '0)) begin
            rd    = '0;
            rbusy = 1'b0;
        end else if (BYPASS != 0 && we && wa == ra) begin
            // Data is forwarded this cycle, so the reader need not wait.
            rd    = wd;
            rbusy = 1'b0;
        end else begin
            rd    = mem[ra];
            rbusy = busy[ra];
        end
    end
endmodule

module regfile_sb #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREAD*AW-1:0]     ra,
    output logic [NREAD*WIDTH-1:0]  rd,
    output logic [NREAD-1:0]        rbusy,
    input  logic                    we,
    input  logic [AW-1:0]           wa,
    input  logic [WIDTH-1:0]        wd,
    input  logic                    iss_en,
    input  logic [AW-1:0]           iss_a,
    output logic                    iss_conflict,
    output logic [AW:0]             busy_cnt
);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [DEPTH-1:0]            busy_q;

    // Qualified write / issue: in range and not the hardwired zero register.
    logic wr_ok, set_ok, same_a, inc, dec;
    assign wr_ok  = we && ({1'b0, wa} < DEPTH_W) && !(ZERO_REG != 0 && wa == '0);
    assign set_ok = iss_en && ({1'b0, iss_a} < DEPTH_W) && !(ZERO_REG != 0 && iss_a == '0);
    assign same_a = (wa == iss_a);

    // A register being written this cycle is not a conflict for a new writer.
    assign iss_conflict = set_ok && busy_q[iss_a] && !(we && same_a);

    // Incremental count: a set of an idle bit adds one; a clear of a busy bit
    // removes one unless a set to the same register wins in the same cycle.
    assign inc = set_ok && !busy_q[iss_a];
    assign dec = wr_ok && busy_q[wa] && !(set_ok && same_a);

    always_ff @(posedge clk) begin
        if (reset) begin
            mem      <= '0;
            busy_q   <= '0;
            busy_cnt <= '0;
        end else begin
            if (wr_ok)  mem[wa]       <= wd;
            if (wr_ok)  busy_q[wa]    <= 1'b0;
            if (set_ok) busy_q[iss_a] <= 1'b1;  // later assignment: set wins
            busy_cnt <= busy_cnt + (AW+1)'(inc) - (AW+1)'(dec);
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rport
        regfile_sb_rport #(
            .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW),
            .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
        ) u_rport (
            .ra    (ra[i*AW +: AW]),
            .mem   (mem),
            .busy  (busy_q),
            .we    (we),
            .wa    (wa),
            .wd    (wd),
            .rd    (rd[i*WIDTH +: WIDTH]),
            .rbusy (rbusy[i])
        );
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: expected values are queued as stimulus is
// driven and compared against DUT outputs when the cycle is sampled.
//   u0: default (bypass on), u1: same inputs with BYPASS=0,
//   u2: NREAD=3, WIDTH=16, DEPTH=8.
module tb_regfile_sb;
    logic clk = 1'b0;
    logic reset;

    logic [9:0]  ra;
    logic [63:0] rd, rd_nb;
    logic [1:0]  rbusy, rbusy_nb;
    logic        we, iss_en, iss_conflict, conf_nb;
    logic [4:0]  wa, iss_a;
    logic [31:0] wd;
    logic [5:0]  busy_cnt, cnt_nb;

    logic [8:0]  ra2;
    logic [47:0] rd2;
    logic [2:0]  rbusy2, wa2, iss_a2;
    logic        we2, iss_en2, conf2;
    logic [15:0] wd2;
    logic [3:0]  cnt2;

    regfile_sb u0 (
        .clk(clk), .reset(reset), .ra(ra), .rd(rd), .rbusy(rbusy),
        .we(we), .wa(wa), .wd(wd), .iss_en(iss_en), .iss_a(iss_a),
        .iss_conflict(iss_conflict), .busy_cnt(busy_cnt)
    );

    regfile_sb #(.BYPASS(0)) u1 (
        .clk(clk), .reset(reset), .ra(ra), .rd(rd_nb), .rbusy(rbusy_nb),
        .we(we), .wa(wa), .wd(wd), .iss_en(iss_en), .iss_a(iss_a),
        .iss_conflict(conf_nb), .busy_cnt(cnt_nb)
    );

    regfile_sb #(.WIDTH(16), .DEPTH(8), .NREAD(3)) u2 (
        .clk(clk), .reset(reset), .ra(ra2), .rd(rd2), .rbusy(rbusy2),
        .we(we2), .wa(wa2), .wd(wd2), .iss_en(iss_en2), .iss_a(iss_a2),
        .iss_conflict(conf2), .busy_cnt(cnt2)
    );

    always #5 clk = ~clk;

    typedef enum int {
        RD0, RD1, RB0, RB1, CNT, CONF, NB_RD0, NB_RB0, U2_RD0, U2_RD1, U2_RD2, U2_CNT
    } sel_t;
    typedef struct {
        sel_t        sel;
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] obs(input sel_t s);
        case (s)
            RD0:     return rd[31:0];
            RD1:     return rd[63:32];
            RB0:     return 32'(rbusy[0]);
            RB1:     return 32'(rbusy[1]);
            CNT:     return 32'(busy_cnt);
            CONF:    return 32'(iss_conflict);
            NB_RD0:  return rd_nb[31:0];
            NB_RB0:  return 32'(rbusy_nb[0]);
            U2_RD0:  return 32'(rd2[15:0]);
            U2_RD1:  return 32'(rd2[31:16]);
            U2_RD2:  return 32'(rd2[47:32]);
            U2_CNT:  return 32'(cnt2);
            default: return 'x;
        endcase
    endfunction

    task automatic expect_v(input sel_t s, input string tag, input logic [31:0] v);
        q.push_back('{s, tag, v});
    endtask

    // Let combinational outputs settle, then compare every queued expectation.
    task automatic drain();
        exp_t e;
        #1;
        while (q.size() != 0) begin
            e = q.pop_front();
            chk(e.tag, obs(e.sel), e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_addr(input int a0, input int a1);
        ra = {5'(a1), 5'(a0)};
    endtask

    initial begin
        reset = 1'b1;
        ra = '0; we = 0; wa = '0; wd = '0; iss_en = 0; iss_a = '0;
        ra2 = '0; we2 = 0; wa2 = '0; wd2 = '0; iss_en2 = 0; iss_a2 = '0;
        tick();
        reset = 1'b0;

        // Reset state across all registers on both ports.
        for (int r = 0; r < 32; r++) begin
            rd_addr(r, 31 - r);
            expect_v(RD0, "rst_rd0", 0);
            expect_v(RD1, "rst_rd1", 0);
            expect_v(RB0, "rst_rb0", 0);
            expect_v(RB1, "rst_rb1", 0);
            drain();
        end
        expect_v(CNT, "rst_cnt", 0);
        expect_v(CONF, "rst_conf", 0);
        drain();

        // Write r5: bypass forwards in the write cycle, no-bypass sees old value.
        we = 1; wa = 5; wd = 32'hDEADBEEF; rd_addr(5, 0);
        expect_v(RD0, "byp_rd", 32'hDEADBEEF);
        expect_v(NB_RD0, "nobyp_rd", 0);
        expect_v(RD1, "zero_rd", 0);
        drain();
        tick();
        // Write r0: ignored, and never forwarded.
        wa = 0; wd = 32'hFFFFFFFF;
        expect_v(RD0, "r5_mem", 32'hDEADBEEF);
        expect_v(NB_RD0, "r5_mem_nb", 32'hDEADBEEF);
        expect_v(RD1, "r0_byp", 0);
        drain();
        tick();
        we = 0;
        expect_v(RD1, "r0_after", 0);
        drain();

        // Issue r7 then r9.
        iss_en = 1; iss_a = 7; rd_addr(7, 9);
        expect_v(CONF, "iss7_conf", 0);
        drain();
        tick();
        iss_a = 9;
        expect_v(RB0, "r7_busy", 1);
        expect_v(RB1, "r9_idle", 0);
        expect_v(CNT, "cnt1", 1);
        drain();
        tick();
        iss_en = 0;
        expect_v(CNT, "cnt2", 2);
        expect_v(RB1, "r9_busy", 1);
        drain();
        iss_en = 1; iss_a = 7;
        expect_v(CONF, "waw_conf", 1);
        drain();
        tick();
        iss_en = 0;
        expect_v(CNT, "cnt_waw", 2);
        drain();

        // Writeback r7: forwarded so not busy this cycle (no-bypass still busy).
        we = 1; wa = 7; wd = 32'h12345678;
        expect_v(RB0, "wb7_rbusy", 0);
        expect_v(NB_RB0, "wb7_rbusy_nb", 1);
        expect_v(RD0, "wb7_byp", 32'h12345678);
        drain();
        tick();
        we = 0;
        expect_v(CNT, "cnt_wb7", 1);
        expect_v(RB0, "r7_clear", 0);
        expect_v(RD0, "r7_mem", 32'h12345678);
        drain();

        // Retire r9, then busy r3.
        we = 1; wa = 9; wd = 32'h9;
        tick();
        we = 0; iss_en = 1; iss_a = 3;
        expect_v(CNT, "cnt_r9", 0);
        drain();
        tick();
        // Same-cycle issue + write of busy r3: set wins, no conflict.
        we = 1; wa = 3; wd = 32'hA5A5A5A5;
        expect_v(CONF, "r3_conf", 0);
        drain();
        tick();
        we = 0; iss_en = 0; rd_addr(3, 11);
        expect_v(RD0, "r3_mem", 32'hA5A5A5A5);
        expect_v(RB0, "r3_busy", 1);
        expect_v(CNT, "cnt_r3", 1);
        drain();
        // Same-cycle issue + write of idle r11: count rises.
        iss_en = 1; iss_a = 11; we = 1; wa = 11; wd = 32'hB;
        expect_v(CONF, "r11_conf", 0);
        expect_v(RB1, "r11_byp_rb", 0);
        drain();
        tick();
        we = 0; iss_en = 0;
        expect_v(CNT, "cnt_r11", 2);
        expect_v(RB1, "r11_busy", 1);
        drain();

        // Fill the scoreboard.
        iss_en = 1;
        for (int r = 1; r < 32; r++) begin
            iss_a = 5'(r);
            tick();
        end
        iss_a = 0;
        expect_v(CNT, "cnt_full", 31);
        expect_v(CONF, "r0_conf", 0);
        drain();
        tick();
        expect_v(CNT, "cnt_r0_iss", 31);
        drain();
        // Clear r2 while re-issuing busy r1: conflict, count falls.
        iss_a = 1; we = 1; wa = 2; wd = 32'h2;
        expect_v(CONF, "r1_conf", 1);
        drain();
        tick();
        // Issue idle r2 while clearing r5: net zero.
        iss_a = 2; wa = 5; wd = 32'h5;
        expect_v(CNT, "cnt30", 30);
        expect_v(CONF, "r2_conf", 0);
        drain();
        tick();
        iss_en = 0; we = 0;
        expect_v(CNT, "cnt30b", 30);
        drain();

        // Reset concurrent with a write to r4.
        reset = 1; we = 1; wa = 4; wd = 32'h1;
        tick();
        reset = 0; we = 0; rd_addr(4, 2);
        expect_v(CNT, "rst2_cnt", 0);
        expect_v(RD0, "rst2_r4", 0);
        expect_v(RB1, "rst2_rb", 0);
        drain();
        we = 1; wa = 4; wd = 32'h2;
        tick();
        we = 0;
        expect_v(CNT, "post_rst_cnt", 0);
        expect_v(RD0, "post_rst_r4", 2);
        drain();

        // Narrow 3-port instance.
        we2 = 1; wa2 = 6; wd2 = 16'hBEEF;
        tick();
        we2 = 0; ra2 = {3'd2, 3'd6, 3'd6};
        expect_v(U2_RD0, "u2_rd0", 32'hBEEF);
        expect_v(U2_RD1, "u2_rd1", 32'hBEEF);
        expect_v(U2_RD2, "u2_rd2", 0);
        drain();
        iss_en2 = 1;
        for (int r = 0; r < 8; r++) begin
            iss_a2 = 3'(r);
            tick();
        end
        iss_en2 = 0;
        expect_v(U2_CNT, "u2_cnt", 7);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised scoreboarded register file: the successor to the 3-port `regfile` used by the single-cycle and pipelined cores. It is generalised in data width, register count and number of read ports. It adds optional write-to-read bypass, optional hardwired-zero register 0, and a per-register busy scoreboard with an outstanding-write counter, so pipeline hazard logic can query it directly. It sits in the decode stage: reads are combinational, writes and scoreboard updates happen on the rising clock edge.

## Interface
- `WIDTH`, 32, data width in bits.
- `DEPTH`, 32, number of registers; `AW = $clog2(DEPTH)`.
- `NREAD`, 2, number of read ports (1..8).
- `ZERO_REG`, 1, when 1, register 0 reads as 0 and is never written or marked busy.
- `BYPASS`, 1, when 1, same-cycle write data is forwarded to matching read ports.

Ports:
- `clk`, input, 1, single clock; all state updates on the rising edge.
- `reset`, input, 1, synchronous, active-high.
- `ra`, input, NREAD*AW, read addresses; port i is `ra[i*AW +: AW]`.
- `rd`, output, NREAD*WIDTH, read data; port i is `rd[i*WIDTH +: WIDTH]`.
- `rbusy`, output, NREAD, per-port busy flag for the addressed register.
- `we`, input, 1, write enable (writeback).
- `wa`, input, AW, write address.
- `wd`, input, WIDTH, write data.
- `iss_en`, input, 1, issue of an instruction that will write `iss_a`.
- `iss_a`, input, AW, destination register of the issued instruction.
- `iss_conflict`, output, 1, WAW conflict: the issue targets a register that is still busy.
- `busy_cnt`, output, AW+1, number of registers currently marked busy.

## Operation
- Storage: DEPTH x WIDTH array `mem`; scoreboard: DEPTH-bit vector `busy_q`; `busy_cnt` is a registered counter.
- Write: on a rising edge, if `we` and not (`ZERO_REG` and `wa`==0), then `mem[wa] <= wd`.
- Read port i, combinational, first matching rule applies:
  - `ZERO_REG` and `ra_i`==0 gives 0.
  - `BYPASS` and `we` and `wa`==`ra_i` gives `wd`.
  - Otherwise `mem[ra_i]`.
- `rbusy[i]` = `busy_q[ra_i]`, except:
  - it is 0 when `ZERO_REG` and `ra_i`==0;
  - it is 0 when `BYPASS` and `we` and `wa`==`ra_i` (data is forwarded this cycle).
- Scoreboard update per edge, with `s` = `iss_en` and `c` = `we`:
  - `s` sets `busy_q[iss_a]`.
  - `c` clears `busy_q[wa]`.
  - If `iss_a`==`wa` and both are asserted, set wins (a new writer was issued).
  - Register 0 is excluded from both set and clear when `ZERO_REG`.
- `busy_cnt` next value = popcount of next `busy_q`. It is maintained incrementally (+1, -1, or 0), never recomputed by sweeping the vector. It must always equal the popcount.
- `iss_conflict` = `iss_en` & `busy_q[iss_a]` & ~(`we` & `wa`==`iss_a`), and is 0 for register 0 when `ZERO_REG`. On a conflict the bit simply stays set; stalling is the issuer's responsibility. The block tracks no writer count.
- Writes to a non-busy register are legal and do not change `busy_cnt`.
- Out-of-range addresses (when DEPTH is not a power of 2):
  - reads return 0 with `rbusy`=0;
  - writes and issues to them are ignored.

## Timing
- Read latency 0: `rd` and `rbusy` follow `ra`, `we`, `wa`, `wd` combinationally.
- A write at edge N is visible from storage after edge N. With `BYPASS`=1 it is also visible in the cycle before edge N.
- Busy set or clear takes effect after the edge. `iss_conflict` is combinational within the issue cycle.
- Reset, taken at the rising edge while `reset`=1:
  - every `mem` entry becomes 0, `busy_q` becomes 0, `busy_cnt` becomes 0;
  - reset overrides `we` and `iss_en` in the same cycle.
- Outputs after reset: `rd`=0 on all ports, `rbusy`=0, `busy_cnt`=0. `iss_conflict`=0 until something is issued.
- Reset mid-operation: an in-flight busy bit is lost. A later writeback to that register is still accepted and the count does not underflow.

## Test plan
- Reset, then read all 32 registers on both ports: every `rd`=0, `rbusy`=0, `busy_cnt`=0.
- Write 0xDEADBEEF to r5, then r0 (`ZERO_REG`=1) with 0xFFFFFFFF:
  - after the edge, `ra`={5,0} gives `rd`={0xDEADBEEF,0};
  - in the write cycle, reading r5 returns 0xDEADBEEF via bypass;
  - with `BYPASS`=0, the same read returns the old value 0.
- Issue r7, then issue r9:
  - `busy_cnt`=2 and reading r7 gives `rbusy`=1;
  - issue r7 again gives `iss_conflict`=1 and `busy_cnt` stays 2;
  - write r7 with 0x12345678: `rbusy` for r7 is 0 in that cycle and `busy_cnt`=1 after the edge.
- Same-cycle `iss_en` to r3 and `we` to r3 with 0xA5A5A5A5: after the edge `mem[3]`=0xA5A5A5A5, r3 is still busy, `busy_cnt`=1, and `iss_conflict` was 0 (r3 was already busy and is written in that cycle, so the conflict rule excludes it).
- Fill the scoreboard by issuing r1..r31: `busy_cnt`=31. Assert `reset` concurrently with a write to r4 of 0x1: `busy_cnt`=0 and r4 reads 0. A subsequent write to r4 leaves `busy_cnt`=0.
- NREAD=3, WIDTH=16, DEPTH=8 instance: write 0xBEEF to r6, then `ra`={6,6,2} gives `rd`={0xBEEF,0xBEEF,0x0000}; the counter is 4 bits wide.
